// File: rtl/mmio_timer_if.sv
// rtl/mmio_timer_if.sv - core data-bus bundle between the core mem_* port and the machine timer
interface mmio_timer_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [1:0]  mem_width;
  logic [31:0] rd_data;
  logic        sel;

  modport master (
    output mem_addr, mem_dout, mem_read_en, mem_write_en, mem_width,
    input  rd_data, sel
  );

  modport slave (
    input  mem_addr, mem_dout, mem_read_en, mem_write_en, mem_width,
    output rd_data, sel
  );
endinterface

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped 64-bit machine timer with prescaler, compare and sticky irq
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'hC000_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  mmio_timer_if.slave bus,
  output logic        irq
);
  localparam logic [5:0] OFF_MTIME_LO = 6'd0;
  localparam logic [5:0] OFF_MTIME_HI = 6'd1;
  localparam logic [5:0] OFF_CMP_LO   = 6'd2;
  localparam logic [5:0] OFF_CMP_HI   = 6'd3;
  localparam logic [5:0] OFF_CTRL     = 6'd4;
  localparam logic [5:0] OFF_STATUS   = 6'd5;
  localparam logic [5:0] OFF_PRESCALE = 6'd6;

  logic [63:0]           mtime_q, mtime_d, cmp_q, cmp_d;
  logic                  run_q, run_d, irq_en_q, irq_en_d, pending_q, pending_d, irq_q;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic [5:0]            off;
  logic                  wr_en, tick, status_clr;
  logic [31:0]           rd_word, wdata;

  // Sub-word writes merge right-aligned data into the addressed lane of the current word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [1:0] width, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (width)
      2'b10: r = din;
      2'b01: if (lane[1]) r[31:16] = din[15:0]; else r[15:0] = din[15:0];
      2'b00: r[{lane, 3'b000} +: 8] = din[7:0];
      default: r = old;
    endcase
    return r;
  endfunction

  assign bus.sel = (bus.mem_addr[31:8] == BASE_ADDR[31:8]);
  assign off     = bus.mem_addr[7:2];
  assign wr_en   = bus.sel & bus.mem_write_en & (bus.mem_width != 2'b11);

  always_comb begin
    rd_word = '0;
    case (off)
      OFF_MTIME_LO: rd_word = mtime_q[31:0];
      OFF_MTIME_HI: rd_word = mtime_q[63:32];
      OFF_CMP_LO:   rd_word = cmp_q[31:0];
      OFF_CMP_HI:   rd_word = cmp_q[63:32];
      OFF_CTRL:     rd_word = {30'b0, irq_en_q, run_q};
      OFF_STATUS:   rd_word = {31'b0, pending_q};
      OFF_PRESCALE: rd_word = 32'(prescale_q);
      default:      rd_word = '0;
    endcase
  end

  assign bus.rd_data = (bus.sel & bus.mem_read_en) ? rd_word : '0;
  assign wdata       = merge(rd_word, bus.mem_dout, bus.mem_width, bus.mem_addr[1:0]);
  // STATUS is write-1-to-clear, so only a write whose lane covers bit 0 can clear it.
  assign status_clr  = bus.mem_dout[0] &
                       ((bus.mem_width == 2'b10) ||
                        (bus.mem_width == 2'b01 && !bus.mem_addr[1]) ||
                        (bus.mem_width == 2'b00 && bus.mem_addr[1:0] == 2'b00));

  always_comb begin
    tick       = 1'b0;
    pcnt_d     = pcnt_q;
    mtime_d    = mtime_q;
    cmp_d      = cmp_q;
    run_d      = run_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    pending_d  = pending_q;

    if (run_q) begin
      if (pcnt_q == prescale_q) begin
        tick   = 1'b1;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + PRESCALE_W'(1);
      end
    end
    if (tick) mtime_d = mtime_q + 64'd1;

    // A bus write to either mtime half replaces the whole increment for that cycle.
    if (wr_en) begin
      case (off)
        OFF_MTIME_LO: mtime_d = {mtime_q[63:32], wdata};
        OFF_MTIME_HI: mtime_d = {wdata, mtime_q[31:0]};
        OFF_CMP_LO:   cmp_d   = {cmp_q[63:32], wdata};
        OFF_CMP_HI:   cmp_d   = {wdata, cmp_q[31:0]};
        OFF_CTRL: begin
          run_d    = wdata[0];
          irq_en_d = wdata[1];
        end
        OFF_STATUS:   if (status_clr) pending_d = 1'b0;
        OFF_PRESCALE: begin
          prescale_d = wdata[PRESCALE_W-1:0];
          pcnt_d     = '0;
        end
        default: ;
      endcase
    end

    if (run_q && (mtime_q >= cmp_q)) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_q    <= '0;
      cmp_q      <= '1;
      run_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      cmp_q      <= cmp_d;
      run_q      <= run_d;
      irq_en_q   <= irq_en_d;
      pending_q  <= pending_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      irq_q      <= pending_q & irq_en_q;
    end
  end

  assign irq = irq_q;
endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped machine timer on the core's data bus, directly downstream of the core's mem_* port; the core's ext_interrupt input is fed from this block's irq output.
- Holds a 64-bit free-running counter with programmable prescale and a 64-bit compare register.
- Raises a sticky pending flag when the counter reaches the compare value.
- Reads are combinational and complete in the same cycle, as the core bus requires. Writes commit on the clock edge.

Parameters:
- BASE_ADDR, 32'hC000_0000, window base; decode compares addr[31:8] only.
- PRESCALE_W, 16, width of the prescale register and prescale counter.

Ports:
- clk  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-low reset.
- mem_addr  in  32  byte address from core.
- mem_dout  in  32  write data from core; sub-word data is right-aligned.
- mem_read_en  in  1  read strobe.
- mem_write_en  in  1  write strobe, sampled at posedge clk.
- mem_width  in  2  00 byte, 01 half, 10 word, 11 invalid.
- rd_data  out  32  read data, combinational.
- sel  out  1  high when mem_addr[31:8] equals BASE_ADDR[31:8]; the system mux uses it.
- irq  out  1  pending AND irq_en; connects to core ext_interrupt.

Behaviour:
- Register map, offsets taken from addr[7:2]:
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 CMP_LO
  - 0x0C CMP_HI
  - 0x10 CTRL: bit0 run, bit1 irq_en, other bits read 0.
  - 0x14 STATUS: bit0 pending, write 1 to clear.
  - 0x18 PRESCALE: low PRESCALE_W bits.
  - All other offsets read 0 and ignore writes.
- Reset (reset=0, asynchronous):
  - mtime=0, CMP=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, pending=0, PRESCALE=0, prescale counter=0.
  - Outputs: irq=0; rd_data=0 unless a read is active.
- Read path:
  - rd_data = aligned register word when sel & mem_read_en; addr[1:0] is ignored.
  - rd_data = 0 otherwise.
  - Zero-cycle latency; no state change on read.
- Write path (posedge, sel & mem_write_en):
  - width 10: full word.
  - width 01: mem_dout[15:0] into halfword lane addr[1].
  - width 00: mem_dout[7:0] into byte lane addr[1:0].
  - width 11: ignored, no register changes.
- Prescaler:
  - When run=1, the counter increments each cycle.
  - When counter==PRESCALE, a tick is issued and the counter returns to 0. PRESCALE=0 gives a tick every cycle.
  - When run=0, the counter holds.
  - Any write to PRESCALE also clears the counter.
- mtime:
  - Increments by 1 on each tick as a full 64-bit add; carry from LO propagates into HI in the same cycle.
  - Wraps from 2^64-1 to 0.
  - A write to MTIME_LO or MTIME_HI in a tick cycle takes priority: the written value is loaded and that cycle's increment is dropped. The non-written half keeps its value with no carry applied.
- Compare and pending:
  - Every cycle, if run=1 and mtime >= CMP (unsigned 64-bit, compared on registered values), pending is set next cycle.
  - A STATUS write with bit0=1 clears pending. If the set condition holds in the same cycle, set wins.
  - Writing CMP does not clear pending.
- irq:
  - Registered: irq = pending & irq_en. It asserts exactly one cycle after pending rises, or the cycle after irq_en is written to 1 while pending is set.
- Mid-operation reset: every register returns to its reset value immediately, and irq drops combinationally with reset.

Test Plan:
- Reset value readback → read 0x08 = FFFF_FFFF, 0x0C = FFFF_FFFF, 0x10 = 0, 0x14 = 0; irq=0.
- Prescale → write PRESCALE=3, CTRL=1; after 40 cycles MTIME_LO = 10 (±1 for the start edge). With PRESCALE=0, mtime advances by 1 per cycle.
- Carry → write MTIME_LO=FFFF_FFFF, MTIME_HI=0, PRESCALE=0, run=1; next tick reads LO=0, HI=1. Also load LO=HI=FFFF_FFFF; the next tick wraps both halves to 0.
- Compare interrupt → CMP=20, CTRL=3, mtime=0, PRESCALE=0; pending rises when mtime ≥ 20 and irq rises one cycle later. STATUS write 1 while mtime=25 ≥ CMP leaves pending=1 (set wins). Then CMP=FFFF_FFFF_FFFF_FFFF and STATUS write 1 clears pending and irq.
- Sub-word writes → word write CMP_LO=0; then byte write 0xAB at offset 0x0A gives CMP_LO=00AB_0000; half write 0x1234 at 0x08 gives 00AB_1234; width 11 write leaves it unchanged.
- Decode and priority:
  - Accesses with addr[31:8] ≠ base give sel=0 and rd_data=0, with no register change; unmapped offset 0x1C reads 0.
  - A write to MTIME_LO coinciding with a tick loads exactly the written value.
  - Asserting reset mid-count zeroes mtime and drops irq within the same cycle.
